// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: merges per-stage stall requests, sequences
// exception/ERET flushes with a redirect PC, and tracks stall watchdog/statistics.
module pipe_stall_ctrl #(
   parameter int                STAGES  = 6,
   parameter int                NREQ    = 4,
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(32'h0000_0020),
   parameter int                TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   stallreq,
   input  logic              excp_valid,
   input  logic              excp_is_eret,
   input  logic [ADDR_W-1:0] epc,
   output logic [STAGES-1:0] stall,
   output logic              flush,
   output logic [ADDR_W-1:0] new_pc,
   output logic              stall_timeout,
   output logic [31:0]       stall_cycles
);

   localparam logic [0:0] RUN_ST   = 1'b0;
   localparam logic [0:0] FLUSH_ST = 1'b1;
   localparam int         RUN_W    = $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0] TMO_C = RUN_W'(TIMEOUT);

   logic [0:0]        r_state;
   logic              r_flush;
   logic [ADDR_W-1:0] r_new_pc;
   logic              r_timeout;
   logic [RUN_W-1:0]  r_stall_run;
   logic [31:0]       r_stall_cycles;
   logic [STAGES-1:0] w_stall;

   // Highest requester wins: it and everything upstream of it hold.
   always_comb begin
      w_stall = '0;
      if (!rst) begin
         w_stall = '0;
      end else if (r_state == FLUSH_ST) begin
         w_stall = '0;
      end else if (excp_valid) begin
         w_stall = {STAGES{1'b1}};
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (stallreq[i]) begin
               w_stall = {STAGES{1'b1}} >> (STAGES - 2 - i);
            end else begin
               w_stall = w_stall;
            end
         end
      end
   end

   // RUN/FLUSH sequencing; the redirect target is latched on the freeze cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= RUN_ST;
         r_flush  <= 1'b0;
         r_new_pc <= '0;
      end else if (r_state == FLUSH_ST) begin
         r_state  <= RUN_ST;
         r_flush  <= 1'b0;
         r_new_pc <= '0;
      end else if (excp_valid) begin
         r_state  <= FLUSH_ST;
         r_flush  <= 1'b1;
         r_new_pc <= excp_is_eret ? epc : EXC_VEC;
      end else begin
         r_state  <= RUN_ST;
         r_flush  <= 1'b0;
         r_new_pc <= '0;
      end
   end

   // Watchdog run length; the sticky flag is only released by a flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_run <= '0;
         r_timeout   <= 1'b0;
      end else begin
         if (!w_stall[0]) begin
            r_stall_run <= '0;
         end else if (r_stall_run != TMO_C) begin
            r_stall_run <= r_stall_run + RUN_W'(1);
         end else begin
            r_stall_run <= r_stall_run;
         end

         if (r_state == FLUSH_ST) begin
            r_timeout <= 1'b0;
         end else if (w_stall[0] && (r_stall_run >= (TMO_C - RUN_W'(1)))) begin
            r_timeout <= 1'b1;
         end else begin
            r_timeout <= r_timeout;
         end
      end
   end

   // Saturating total of stalled cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cycles <= 32'd0;
      end else if (w_stall[0] && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end else begin
         r_stall_cycles <= r_stall_cycles;
      end
   end

   assign stall         = w_stall;
   assign flush         = r_flush;
   assign new_pc        = r_new_pc;
   assign stall_timeout = r_timeout;
   assign stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed table-driven bench for pipe_stall_ctrl (TIMEOUT=8) plus watchdog and
// reset-during-flush sequences.
module tb_pipe_stall_ctrl;

   localparam int STAGES = 6;
   localparam int NREQ   = 4;
   localparam int ADDR_W = 32;
   localparam int TMO    = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]   stallreq = '0;
   logic              excp_valid = 1'b0;
   logic              excp_is_eret = 1'b0;
   logic [ADDR_W-1:0] epc = '0;
   logic [STAGES-1:0] stall;
   logic              flush;
   logic [ADDR_W-1:0] new_pc;
   logic              stall_timeout;
   logic [31:0]       stall_cycles;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_sc  = 32'd0;

   typedef struct {
      logic [3:0]  sr;
      logic        ev;
      logic        eret;
      logic [31:0] epc;
      logic [5:0]  st;
      logic        fl;
      logic [31:0] pc;
      logic        to;
   } vec_t;

   vec_t vecs[16];

   pipe_stall_ctrl #(
      .STAGES (STAGES),
      .NREQ   (NREQ),
      .ADDR_W (ADDR_W),
      .EXC_VEC(32'h0000_0020),
      .TIMEOUT(TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq     (stallreq),
      .excp_valid   (excp_valid),
      .excp_is_eret (excp_is_eret),
      .epc          (epc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .stall_timeout(stall_timeout),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle: drive after the rising edge, check mid-cycle on the falling edge.
   task automatic step(input string tag, input logic [3:0] sr, input logic ev, input logic eret,
                       input logic [31:0] e_pc, input logic [5:0] st, input logic fl,
                       input logic [31:0] pc, input logic to);
      @(posedge clk);
      #1;
      stallreq     = sr;
      excp_valid   = ev;
      excp_is_eret = eret;
      epc          = e_pc;
      @(negedge clk);
      chk({tag, ".stall"},         64'(stall),         64'(st));
      chk({tag, ".flush"},         64'(flush),         64'(fl));
      chk({tag, ".new_pc"},        64'(new_pc),        64'(pc));
      chk({tag, ".stall_timeout"}, 64'(stall_timeout), 64'(to));
      chk({tag, ".stall_cycles"},  64'(stall_cycles),  64'(exp_sc));
      if (st[0]) exp_sc = exp_sc + 32'd1;
   endtask

   initial begin
      vecs[0]  = '{4'b0000, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0,         1'b0};
      vecs[1]  = '{4'b0010, 1'b0, 1'b0, 32'h0,         6'b000111, 1'b0, 32'h0,         1'b0};
      vecs[2]  = '{4'b0110, 1'b0, 1'b0, 32'h0,         6'b001111, 1'b0, 32'h0,         1'b0};
      vecs[3]  = '{4'b1000, 1'b0, 1'b0, 32'h0,         6'b011111, 1'b0, 32'h0,         1'b0};
      vecs[4]  = '{4'b0001, 1'b0, 1'b0, 32'h0,         6'b000011, 1'b0, 32'h0,         1'b0};
      vecs[5]  = '{4'b0000, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0,         1'b0};
      vecs[6]  = '{4'b0000, 1'b1, 1'b0, 32'h1234_5678, 6'b111111, 1'b0, 32'h0,         1'b0};
      vecs[7]  = '{4'b0000, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b1, 32'h0000_0020, 1'b0};
      vecs[8]  = '{4'b0000, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0,         1'b0};
      vecs[9]  = '{4'b0010, 1'b1, 1'b1, 32'hBFC0_0100, 6'b111111, 1'b0, 32'h0,         1'b0};
      vecs[10] = '{4'b0010, 1'b1, 1'b1, 32'hBFC0_0100, 6'b000000, 1'b1, 32'hBFC0_0100, 1'b0};
      vecs[11] = '{4'b0010, 1'b1, 1'b1, 32'hBFC0_0100, 6'b111111, 1'b0, 32'h0,         1'b0};
      vecs[12] = '{4'b0010, 1'b0, 1'b1, 32'hBFC0_0100, 6'b000000, 1'b1, 32'hBFC0_0100, 1'b0};
      vecs[13] = '{4'b0000, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0,         1'b0};
      vecs[14] = '{4'b0011, 1'b0, 1'b0, 32'h0,         6'b000111, 1'b0, 32'h0,         1'b0};
      vecs[15] = '{4'b0000, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0,         1'b0};

      // Reset held with random inputs: everything must read zero.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         stallreq     = 4'($urandom_range(15, 1));
         excp_valid   = 1'($urandom_range(1, 0));
         excp_is_eret = 1'($urandom_range(1, 0));
         epc          = 32'($urandom);
         @(negedge clk);
         chk("rst.stall",         64'(stall),         64'd0);
         chk("rst.flush",         64'(flush),         64'd0);
         chk("rst.new_pc",        64'(new_pc),        64'd0);
         chk("rst.stall_timeout", 64'(stall_timeout), 64'd0);
         chk("rst.stall_cycles",  64'(stall_cycles),  64'd0);
      end
      stallreq   = '0;
      excp_valid = 1'b0;
      rst        = 1'b1;

      for (int v = 0; v < 16; v++) begin
         step($sformatf("vec%0d", v), vecs[v].sr, vecs[v].ev, vecs[v].eret, vecs[v].epc,
              vecs[v].st, vecs[v].fl, vecs[v].pc, vecs[v].to);
      end

      // Watchdog: 7 stalled cycles stay below the threshold.
      for (int i = 0; i < 7; i++) step("wd7", 4'b0010, 1'b0, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0);
      step("wd7.idle", 4'b0000, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);
      // 8 stalled cycles: flag rises on the 8th edge and stays after release.
      for (int i = 0; i < 8; i++) step("wd8", 4'b0010, 1'b0, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) step("wd8.hold", 4'b0000, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b1);
      step("wd.freeze", 4'b0000, 1'b1, 1'b0, 32'h0, 6'b111111, 1'b0, 32'h0,         1'b1);
      step("wd.flush",  4'b0000, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h0000_0020, 1'b1);
      step("wd.clear",  4'b0000, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0,         1'b0);

      // Reset asserted in the FLUSH cycle.
      step("rf.freeze", 4'b0000, 1'b1, 1'b0, 32'h0, 6'b111111, 1'b0, 32'h0,         1'b0);
      step("rf.flush",  4'b0100, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h0000_0020, 1'b0);
      #1;
      rst = 1'b0;
      #1;
      chk("rf.flush_drop",  64'(flush),        64'd0);
      chk("rf.new_pc_drop", 64'(new_pc),       64'd0);
      chk("rf.stall_drop",  64'(stall),        64'd0);
      chk("rf.cycles_drop", 64'(stall_cycles), 64'd0);
      exp_sc   = 32'd0;
      stallreq = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      step("rf.post0", 4'b0000, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);
      step("rf.post1", 4'b0000, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);
      step("rf.post2", 4'b1000, 1'b0, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0);
      step("rf.post3", 4'b0000, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Parametrised pipeline control unit for the five-stage CPU. It merges per-stage stall requests into a per-stage stall vector, using the "freeze everything at and upstream of the requester" rule. It adds registered exception/ERET flush sequencing with redirect PC, a stall watchdog, and a saturating stall-cycle counter. It sits beside the pipeline registers and drives their stall/flush inputs and the PC redirect mux.

## Interface
- STAGES, 6, number of stall bits; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB
- NREQ, 4, stall request sources; stallreq[i] originates in stage i+1; legal range 1..STAGES-2
- ADDR_W, 32, PC width
- EXC_VEC, 32'h0000_0020, exception entry address (ADDR_W bits)
- TIMEOUT, 1024, consecutive stalled cycles that trip the watchdog; ≥2
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- stallreq  in  NREQ  per-stage stall requests, level, combinational into stall
- excp_valid  in  1  exception/ERET committing in MEM this cycle
- excp_is_eret  in  1  qualifies excp_valid: 1 = ERET, 0 = exception
- epc  in  ADDR_W  return address used for ERET
- stall  out  STAGES  per-stage hold enables
- flush  out  1  one-cycle pipeline flush, registered
- new_pc  out  ADDR_W  redirect target, valid when flush=1, else 0
- stall_timeout  out  1  sticky watchdog flag
- stall_cycles  out  32  saturating count of cycles with stall[0]=1

## Operation
- State machine RUN / FLUSH; reset state RUN.
- RUN, excp_valid=0: let k = highest i+1 with stallreq[i]=1.
  - stall[k:0]=1; all other bits 0. Stage k+1 receives a bubble.
  - No request → stall=0.
  - Example: STAGES=6, ID request only → 6'b000111; EX request → 6'b001111; ID+EX → 6'b001111.
- RUN, excp_valid=1: stall = all ones (freeze); stallreq ignored.
  - Capture target: excp_is_eret ? epc : EXC_VEC.
  - Next state FLUSH.
- FLUSH (exactly one cycle):
  - flush=1, new_pc = captured target, stall=0.
  - excp_valid and stallreq are ignored.
  - Next state RUN.
- Watchdog: stall_run counter, width $clog2(TIMEOUT+1).
  - Increments each cycle stall[0]=1, saturating at TIMEOUT.
  - Clears on any cycle with stall[0]=0.
  - When the count reaches TIMEOUT, stall_timeout sets and holds until the FLUSH state or reset.
  - The freeze cycle of an exception counts as stalled.
- stall_cycles increments on every cycle with stall[0]=1 and saturates at 32'hFFFF_FFFF (no wrap).
- Priority: rst > FLUSH state > excp_valid > stallreq.

## Timing
- Reset (rst=0, asynchronous): state=RUN, flush=0, new_pc=0, stall_timeout=0, stall_cycles=0, stall_run=0.
  - stall=0 for as long as rst=0.
- stall is combinational from stallreq, excp_valid and state: zero latency, valid in the same cycle.
- flush and new_pc are registered: asserted in the cycle after excp_valid is sampled, for exactly one cycle.
- stall_timeout rises on the clock edge at which stall_run reaches TIMEOUT, i.e. after TIMEOUT consecutive stalled edges.
- Back-to-back exception (excp_valid held high across RUN→FLUSH→RUN):
  - Ignored in FLUSH.
  - Re-sampled in the following RUN cycle, which starts a new freeze/flush pair.
- Reset asserted mid-FLUSH: all outputs clear immediately; no flush pulse after release.
- Reset release: first edge with rst=1 behaves as RUN.

## Test plan
- Reset: drive rst=0 with random inputs → stall=0, flush=0, new_pc=0, stall_timeout=0, stall_cycles=0; release, stallreq=0 → stall=6'b000000.
- Stall merge: stallreq=4'b0010 → stall=6'b000111; 4'b0110 → 6'b001111; 4'b1000 → 6'b011111; 4'b0001 → 6'b000011; each stall cycle increments stall_cycles by 1.
- Exception: excp_valid=1, excp_is_eret=0 for one cycle → that cycle stall=6'b111111; next cycle flush=1, new_pc=32'h20, stall=0; cycle after, flush=0, new_pc=0.
- ERET held with stallreq active: epc=32'hBFC0_0100, excp_is_eret=1, stallreq=4'b0010, excp_valid held 3 cycles → freeze; flush with new_pc=32'hBFC0_0100; freeze; flush again; stallreq ignored throughout.
- Watchdog (TIMEOUT=8): stallreq=4'b0010 for 7 cycles then 0 → stall_timeout=0; hold 8 cycles → stall_timeout=1 stays high after release; an exception flush clears it.
- Reset mid-flush: assert rst=0 in the FLUSH cycle → flush drops immediately; after release, no flush pulse and stall_cycles=0.
